// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the W stage (P) and the MDU (M).
// Optional trace output enabled by defining RF_WB_ARB_TRACE_EN.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,
    output logic        p_ready,
    input  logic        m_valid,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic [31:0] m_pc,
    output logic        m_ready,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] rf_wpc,
    input  logic [4:0]  qa1,
    input  logic [4:0]  qa2,
    output logic        hit1,
    output logic        hit2
);

    typedef enum logic {NORMAL, FORCE_M} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    logic [7:0]  starve_cnt;
    logic [7:0]  starve_cnt_nxt;
    logic        gnt_p;
    logic        gnt_m;

    // Grants are suppressed while reset is high so nothing reaches the RF port.
    always_comb begin
        gnt_p = 1'b0;
        gnt_m = 1'b0;
        if (!reset) begin
            if (state == FORCE_M) begin
                if (m_valid)      gnt_m = 1'b1;
                else if (p_valid) gnt_p = 1'b1;
            end else begin
                if (p_valid)      gnt_p = 1'b1;
                else if (m_valid) gnt_m = 1'b1;
            end
        end
    end

    assign p_ready = gnt_p;
    assign m_ready = gnt_m;

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!m_valid || gnt_m)
            starve_cnt_nxt = 8'd0;
        else if (starve_cnt != 8'hFF)
            starve_cnt_nxt = starve_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= 8'd0;
            rf_we      <= 1'b0;
            rf_a3      <= 5'd0;
            rf_wd      <= 32'd0;
            rf_wpc     <= 32'd0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            case (state)
                NORMAL:  if (starve_cnt_nxt == LIMIT) state <= FORCE_M;
                FORCE_M: if (gnt_m || !m_valid)       state <= NORMAL;
                default: state <= NORMAL;
            endcase
            // Writes to $0 are accepted but never enabled on the port.
            if (gnt_p) begin
                rf_we  <= (p_addr != 5'd0);
                rf_a3  <= p_addr;
                rf_wd  <= p_data;
                rf_wpc <= p_pc;
            end else if (gnt_m) begin
                rf_we  <= (m_addr != 5'd0);
                rf_a3  <= m_addr;
                rf_wd  <= m_data;
                rf_wpc <= m_pc;
            end else begin
                rf_we  <= 1'b0;
            end
        end
    end

    assign hit1 = rf_we && (qa1 == rf_a3) && (qa1 != 5'd0);
    assign hit2 = rf_we && (qa2 == rf_a3) && (qa2 != 5'd0);

`ifdef RF_WB_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (gnt_p && p_addr != 5'd0)
                $display("%d@%h: $%d <= %h", $time, p_pc, p_addr, p_data);
            else if (gnt_m && m_addr != 5'd0)
                $display("%d@%h: $%d <= %h (mdu)", $time, m_pc, m_addr, m_data);
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors plus a per-cycle comparison against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, m_valid;
    logic [4:0]  p_addr, m_addr, qa1, qa2;
    logic [31:0] p_data, p_pc, m_data, m_pc;
    logic        p_ready, m_ready, rf_we, hit1, hit2;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, rf_wpc;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc), .p_ready(p_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc), .m_ready(m_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wpc(rf_wpc),
        .qa1(qa1), .qa2(qa2), .hit1(hit1), .hit2(hit2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the last granted write and how many consecutive cycles M has been refused.
    logic        mdl_we;
    logic [4:0]  mdl_a3;
    logic [31:0] mdl_wd, mdl_wpc;
    int          m_wait;

    initial begin
        mdl_we = 1'b0; mdl_a3 = '0; mdl_wd = '0; mdl_wpc = '0; m_wait = 0;
        forever begin
            logic exp_p, exp_m, exp_h1, exp_h2;
            @(negedge clk);
            if (reset) begin
                mdl_we = 1'b0; mdl_a3 = '0; mdl_wd = '0; mdl_wpc = '0; m_wait = 0;
                exp_p = 1'b0; exp_m = 1'b0;
            end else begin
                exp_m = m_valid && (!p_valid || m_wait >= STARVE_LIMIT);
                exp_p = p_valid && !exp_m;
            end
            exp_h1 = mdl_we && (qa1 == mdl_a3) && (qa1 != 5'd0);
            exp_h2 = mdl_we && (qa2 == mdl_a3) && (qa2 != 5'd0);
            check("mdl_p_ready", {31'd0, p_ready}, {31'd0, exp_p});
            check("mdl_m_ready", {31'd0, m_ready}, {31'd0, exp_m});
            check("mdl_rf_we",   {31'd0, rf_we},   {31'd0, mdl_we});
            check("mdl_rf_a3",   {27'd0, rf_a3},   {27'd0, mdl_a3});
            check("mdl_rf_wd",   rf_wd,   mdl_wd);
            check("mdl_rf_wpc",  rf_wpc,  mdl_wpc);
            check("mdl_hit1",    {31'd0, hit1},    {31'd0, exp_h1});
            check("mdl_hit2",    {31'd0, hit2},    {31'd0, exp_h2});
            @(posedge clk);
            if (reset) begin
                mdl_we = 1'b0; mdl_a3 = '0; mdl_wd = '0; mdl_wpc = '0; m_wait = 0;
            end else begin
                if (exp_p) begin
                    mdl_we = (p_addr != 0); mdl_a3 = p_addr; mdl_wd = p_data; mdl_wpc = p_pc;
                end else if (exp_m) begin
                    mdl_we = (m_addr != 0); mdl_a3 = m_addr; mdl_wd = m_data; mdl_wpc = m_pc;
                end else begin
                    mdl_we = 1'b0;
                end
                if (m_valid && !exp_m) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
                else                   m_wait = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic pr, mr;
        reset = 1'b1;
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234; p_pc = 32'h100;
        m_valid = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
        qa1 = '0; qa2 = '0;

        // Reset state: no grants even with a request pending
        sample();
        check("rst_p_ready", {31'd0, p_ready}, 32'd0);
        check("rst_rf_we",   {31'd0, rf_we},   32'd0);
        check("rst_rf_a3",   {27'd0, rf_a3},   32'd0);
        check("rst_rf_wd",   rf_wd,  32'd0);
        check("rst_rf_wpc",  rf_wpc, 32'd0);
        step();
        reset = 1'b0; p_valid = 1'b0;

        // P only
        step();
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234; p_pc = 32'h100; qa1 = 5'd5;
        sample();
        check("p_only_ready", {31'd0, p_ready}, 32'd1);
        step();
        p_valid = 1'b0;
        sample();
        check("p_only_we",  {31'd0, rf_we}, 32'd1);
        check("p_only_a3",  {27'd0, rf_a3}, 32'd5);
        check("p_only_wd",  rf_wd,  32'h1234);
        check("p_only_wpc", rf_wpc, 32'h100);
        check("p_only_hit1", {31'd0, hit1}, 32'd1);

        // Conflict: P wins, M goes when P drops
        step();
        p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h33; p_pc = 32'h200;
        m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h44; m_pc = 32'h300; qa2 = 5'd4;
        sample();
        check("cfl_p_ready", {31'd0, p_ready}, 32'd1);
        check("cfl_m_ready", {31'd0, m_ready}, 32'd0);
        step();
        p_valid = 1'b0;
        sample();
        check("cfl_m_ready2", {31'd0, m_ready}, 32'd1);
        check("cfl_a3_p",     {27'd0, rf_a3},   32'd3);
        step();
        m_valid = 1'b0;
        sample();
        check("cfl_a3_m",  {27'd0, rf_a3}, 32'd4);
        check("cfl_wd_m",  rf_wd,  32'h44);
        check("cfl_hit2",  {31'd0, hit2}, 32'd1);

        // Starvation: M forced through on the fifth cycle
        step();
        p_valid = 1'b1; p_addr = 5'd1; p_data = 32'h11; p_pc = 32'h400;
        m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h99; m_pc = 32'h500;
        for (int k = 1; k <= 5; k++) begin
            sample();
            check("stv_m_ready", {31'd0, m_ready}, (k == 5) ? 32'd1 : 32'd0);
            check("stv_p_ready", {31'd0, p_ready}, (k == 5) ? 32'd0 : 32'd1);
            step();
            if (k == 5) begin
                m_addr = 5'd10; m_data = 32'h100; m_pc = 32'h504;
            end
        end
        sample();
        check("stv_back_p", {31'd0, p_ready}, 32'd1);
        check("stv_back_m", {31'd0, m_ready}, 32'd0);
        check("stv_a3",     {27'd0, rf_a3},   32'd9);
        check("stv_wd",     rf_wd, 32'h99);
        step();
        p_valid = 1'b0;
        sample();
        check("stv_m_late", {31'd0, m_ready}, 32'd1);
        step();
        m_valid = 1'b0;

        // Register 0 write: accepted, never enabled
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hFFFF_FFFF; p_pc = 32'h600; qa1 = 5'd0;
        sample();
        check("r0_ready", {31'd0, p_ready}, 32'd1);
        step();
        p_valid = 1'b0;
        sample();
        check("r0_we",   {31'd0, rf_we}, 32'd0);
        check("r0_hit1", {31'd0, hit1},  32'd0);

        // Async reset while in FORCE_M with a write on the port
        step();
        p_valid = 1'b1; p_addr = 5'd2; p_data = 32'h22; p_pc = 32'h700;
        m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h77; m_pc = 32'h800; qa1 = 5'd2;
        repeat (4) step();
        #1;
        check("ar_pre_m_ready", {31'd0, m_ready}, 32'd1);
        check("ar_pre_we",      {31'd0, rf_we},   32'd1);
        reset = 1'b1;
        #1;
        check("ar_we",      {31'd0, rf_we},   32'd0);
        check("ar_a3",      {27'd0, rf_a3},   32'd0);
        check("ar_wd",      rf_wd,  32'd0);
        check("ar_wpc",     rf_wpc, 32'd0);
        check("ar_m_ready", {31'd0, m_ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        sample();
        check("ar_post_p", {31'd0, p_ready}, 32'd1);
        check("ar_post_m", {31'd0, m_ready}, 32'd0);
        check("ar_post_we", {31'd0, rf_we},  32'd0);
        repeat (6) step();
        p_valid = 1'b0; m_valid = 1'b0;

        // Mixed traffic with stable-until-ready requesters, same-address and $0 cases included
        for (int c = 0; c < 60; c++) begin
            sample();
            pr = p_ready; mr = m_ready;
            step();
            if (!p_valid || pr) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_addr  = 5'($urandom_range(0, 7));
                p_data  = $urandom;
                p_pc    = 32'h1000 + 32'(c * 4);
            end
            if (!m_valid || mr) begin
                m_valid = ($urandom_range(0, 2) != 0);
                m_addr  = 5'($urandom_range(0, 7));
                m_data  = $urandom;
                m_pc    = 32'h2000 + 32'(c * 4);
            end
            qa1 = 5'($urandom_range(0, 7));
            qa2 = 5'($urandom_range(0, 7));
        end

        step();
        p_valid = 1'b0; m_valid = 1'b0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
